// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU phase sequencer: state codes, phase codes,
// register indices and the state-to-phase mapping.
package cpu_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LD_R0    = 3'd1;
  localparam state_t ST_LD_R1    = 3'd2;
  localparam state_t ST_LD_INST  = 3'd3;
  localparam state_t ST_EX_ISSUE = 3'd4;
  localparam state_t ST_EX_WAIT  = 3'd5;
  localparam state_t ST_OUT_RD   = 3'd6;
  localparam state_t ST_OUT_VLD  = 3'd7;

  localparam logic [1:0] PH_LOAD = 2'b00;
  localparam logic [1:0] PH_EXEC = 2'b01;
  localparam logic [1:0] PH_OUT  = 2'b10;
  localparam logic [1:0] PH_IDLE = 2'b11;

  localparam int OP_A_REG    = 0;
  localparam int OP_B_REG    = 1;
  localparam int RES_REG_DEF = 2;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_LD_R0, ST_LD_R1, ST_LD_INST: phase_of = PH_LOAD;
      ST_EX_ISSUE, ST_EX_WAIT:        phase_of = PH_EXEC;
      ST_OUT_RD, ST_OUT_VLD:          phase_of = PH_OUT;
      default:                        phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_exec_watchdog.sv
// Counts enabled cycles and flags expiry on the EXEC_TO-th one; clear restarts
// the count.
module cpu_exec_watchdog
  import cpu_ctrl_pkg::*;
#(
  parameter int EXEC_TO = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(EXEC_TO + 1);
  localparam logic [CW-1:0] LAST = CW'(EXEC_TO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                  cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Load/Execute/Output/Idle sequencer for the 8-bit CPU datapath: loads operands
// and program, issues instructions with a start/done handshake, returns result.
module cpu_phase_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DW      = 8,
  parameter int IW      = 8,
  parameter int RAW     = 2,
  parameter int IAW     = 4,
  parameter int RES_REG = RES_REG_DEF,
  parameter int EXEC_TO = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DW-1:0]  in_1,
  input  logic [DW-1:0]  in_2,
  input  logic [IAW:0]   prog_len,
  input  logic           ld_valid,
  input  logic [IW-1:0]  ld_data,
  output logic           ld_ready,
  output logic           reg_wr_en,
  output logic [RAW-1:0] reg_addr,
  output logic [DW-1:0]  reg_wr_data,
  input  logic [DW-1:0]  reg_rd_data,
  output logic           inst_wr_en,
  output logic [IAW-1:0] inst_addr,
  output logic [IW-1:0]  inst_wr_data,
  output logic           exec_start,
  input  logic           exec_done,
  output logic           res_valid,
  output logic [DW-1:0]  res_data,
  input  logic           res_ready,
  output logic [1:0]     phase,
  output logic           busy,
  output logic           err
);

  localparam logic [IAW:0] MAX_LEN = {1'b1, {IAW{1'b0}}};

  state_t        state_q, state_d;
  logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [IAW:0]  len_q, len_d, ld_cnt_q, ld_cnt_d, pc_q, pc_d;
  logic          err_q, err_d;
  logic          wd_expired;

  cpu_exec_watchdog #(.EXEC_TO(EXEC_TO)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_EX_WAIT),
    .enable  (state_q == ST_EX_WAIT),
    .expired (wd_expired)
  );

  assign phase    = phase_of(state_q);
  assign busy     = (state_q != ST_IDLE);
  assign res_data = res_q;
  assign err      = err_q;

  // NOTE: every signal assigned below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_d        = res_q;
    len_d        = len_q;
    ld_cnt_d     = ld_cnt_q;
    pc_d         = pc_q;
    err_d        = err_q;
    ld_ready     = 1'b0;
    reg_wr_en    = 1'b0;
    reg_addr     = '0;
    reg_wr_data  = '0;
    inst_wr_en   = 1'b0;
    inst_addr    = '0;
    inst_wr_data = '0;
    exec_start   = 1'b0;
    res_valid    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d   = in_1;
          op_b_d   = in_2;
          len_d    = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
          ld_cnt_d = '0;
          pc_d     = '0;
          err_d    = 1'b0;
          state_d  = ST_LD_R0;
        end
      end
      ST_LD_R0: begin
        reg_wr_en   = 1'b1;
        reg_addr    = RAW'(OP_A_REG);
        reg_wr_data = op_a_q;
        state_d     = ST_LD_R1;
      end
      ST_LD_R1: begin
        reg_wr_en   = 1'b1;
        reg_addr    = RAW'(OP_B_REG);
        reg_wr_data = op_b_q;
        state_d     = (len_q != '0) ? ST_LD_INST : ST_OUT_RD;
      end
      ST_LD_INST: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          inst_wr_en   = 1'b1;
          inst_addr    = ld_cnt_q[IAW-1:0];
          inst_wr_data = ld_data;
          ld_cnt_d     = ld_cnt_q + 1'b1;
          if (ld_cnt_q == len_q - 1'b1) begin
            pc_d    = '0;
            state_d = ST_EX_ISSUE;
          end
        end
      end
      ST_EX_ISSUE: begin
        inst_addr  = pc_q[IAW-1:0];
        exec_start = 1'b1;
        state_d    = ST_EX_WAIT;
      end
      ST_EX_WAIT: begin
        inst_addr = pc_q[IAW-1:0];
        // A late exec_done still wins over a watchdog expiry in the same cycle.
        if (exec_done) begin
          if (pc_q == len_q - 1'b1) begin
            state_d = ST_OUT_RD;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_EX_ISSUE;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_OUT_RD: begin
        reg_addr = RAW'(RES_REG);
        res_d    = reg_rd_data;
        state_d  = ST_OUT_VLD;
      end
      ST_OUT_VLD: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      len_q    <= '0;
      ld_cnt_q <= '0;
      pc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      len_q    <= len_d;
      ld_cnt_q <= ld_cnt_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Randomized bench for cpu_phase_ctrl: a transaction-level model predicts the
// register writes, program writes, issued PCs and result of each run.
module tb_cpu_phase_ctrl;

  localparam int DW = 8, IW = 8, RAW = 2, IAW = 4, EXEC_TO = 64;

  logic           clk, rst, start;
  logic [DW-1:0]  in_1, in_2;
  logic [IAW:0]   prog_len;
  logic           ld_valid, ld_ready;
  logic [IW-1:0]  ld_data;
  logic           reg_wr_en;
  logic [RAW-1:0] reg_addr;
  logic [DW-1:0]  reg_wr_data, reg_rd_data;
  logic           inst_wr_en;
  logic [IAW-1:0] inst_addr;
  logic [IW-1:0]  inst_wr_data;
  logic           exec_start, exec_done;
  logic           res_valid, res_ready;
  logic [DW-1:0]  res_data;
  logic [1:0]     phase;
  logic           busy, err;

  cpu_phase_ctrl #(.DW(DW), .IW(IW), .RAW(RAW), .IAW(IAW), .RES_REG(2), .EXEC_TO(EXEC_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .in_1(in_1), .in_2(in_2), .prog_len(prog_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
    .inst_wr_en(inst_wr_en), .inst_addr(inst_addr), .inst_wr_data(inst_wr_data),
    .exec_start(exec_start), .exec_done(exec_done),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .phase(phase), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Environment state shared by the drivers, the monitor and the tests.
  logic [IW-1:0] prog [16];
  logic [DW-1:0] res_val;
  logic [DW-1:0] last_res;
  int  ld_mode, ex_lat, stall, ld_idx, ex_wait;
  bit  hang, start_noise;
  int  exec_seen, exwait_cycles, vld_total, vld_seen, unstable;
  logic [DW-1:0]      vld_first;
  logic [RAW+DW-1:0]  reg_log [$];
  logic [IAW+IW-1:0]  inst_log [$];
  logic [IAW-1:0]     ex_log [$];

  // Register file model: only the result register matters for the read path.
  assign reg_rd_data = (reg_addr == 2'd2) ? res_val : 8'h5A;

  // Input drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ld_mode)
      0:       ld_valid = 1'b1;
      1:       ld_valid = ~ld_valid;
      default: ld_valid = 1'($urandom_range(0, 1));
    endcase
    ld_data = (ld_idx < 16) ? prog[ld_idx] : IW'($urandom);
    if (ex_wait > 0) begin
      ex_wait--;
      exec_done = (ex_wait == 0) && !hang;
    end else begin
      exec_done = 1'b0;
    end
    res_ready = res_valid ? (vld_seen >= stall) : 1'($urandom_range(0, 1));
    if (start_noise) start = (phase != 2'b11) && 1'($urandom_range(0, 1));
  end

  // Monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (reg_wr_en)  reg_log.push_back({reg_addr, reg_wr_data});
      if (inst_wr_en) inst_log.push_back({inst_addr, inst_wr_data});
      if (ld_valid && ld_ready) ld_idx++;
      if (exec_start) begin
        ex_log.push_back(inst_addr);
        ex_wait = ex_lat;
      end
      if (phase == 2'b01) exec_seen++;
      if (phase == 2'b01 && !exec_start) exwait_cycles++;
      if (res_valid) begin
        if (vld_seen == 0) vld_first = res_data;
        else if (res_data !== vld_first) unstable++;
        vld_seen++;
        vld_total++;
      end else begin
        vld_seen = 0;
      end
    end
  end

  task automatic do_run(input string name, input logic [DW-1:0] a, b, rv,
                        input logic [IAW:0] plen, input int lmode, lat, stl,
                        input bit hng, input bit noise);
    int n, cyc, exp_ex;
    n = (plen > 5'd16) ? 16 : int'(plen);
    for (int i = 0; i < 16; i++) prog[i] = IW'($urandom);
    res_val = rv; ld_mode = lmode; ex_lat = lat; stall = stl; hang = hng;
    reg_log.delete(); inst_log.delete(); ex_log.delete();
    ld_idx = 0; exec_seen = 0; exwait_cycles = 0; vld_total = 0; unstable = 0;
    @(posedge clk); #2;
    in_1 = a; in_2 = b; prog_len = plen; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; start_noise = noise;
    in_1 = DW'($urandom); in_2 = DW'($urandom); prog_len = (IAW+1)'($urandom);
    cyc = 0;
    while (phase !== 2'b11 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    start_noise = 1'b0;
    total++;
    if (cyc >= 3000) begin
      bad++;
      $display("FAIL %s run_timeout: phase=%b after %0d cycles, want 11", name, phase, cyc);
    end
    total++;
    if (reg_log.size() != 2 || reg_log[0] !== {2'd0, a} || reg_log[1] !== {2'd1, b}) begin
      bad++;
      $display("FAIL %s reg_writes: got %0d writes first=%h, want (0,%h),(1,%h)",
               name, reg_log.size(), (reg_log.size() > 0) ? reg_log[0] : '0, a, b);
    end
    total++;
    if (inst_log.size() != n) begin
      bad++;
      $display("FAIL %s inst_write_count: got %0d want %0d", name, inst_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (inst_log[i] !== {IAW'(i), prog[i]}) begin
          bad++;
          $display("FAIL %s inst_write[%0d]: got %h want %h", name, i, inst_log[i], {IAW'(i), prog[i]});
        end
      end
    end
    exp_ex = hng ? ((n > 0) ? 1 : 0) : n;
    total++;
    if (ex_log.size() != exp_ex) begin
      bad++;
      $display("FAIL %s exec_start_count: got %0d want %0d", name, ex_log.size(), exp_ex);
    end else begin
      for (int i = 0; i < exp_ex; i++) begin
        total++;
        if (ex_log[i] !== IAW'(i)) begin
          bad++;
          $display("FAIL %s exec_pc[%0d]: got %0d want %0d", name, i, ex_log[i], i);
        end
      end
    end
    if (hng) begin
      total++;
      if (err !== 1'b1 || vld_total != 0 || exwait_cycles != EXEC_TO || res_data !== last_res) begin
        bad++;
        $display("FAIL %s timeout: err=%b valid_cycles=%0d wait_cycles=%0d res=%h, want 1 0 %0d %h",
                 name, err, vld_total, exwait_cycles, EXEC_TO, res_data, last_res);
      end
    end else begin
      total++;
      if (exec_seen != n * (1 + lat)) begin
        bad++;
        $display("FAIL %s exec_cycles: got %0d want %0d", name, exec_seen, n * (1 + lat));
      end
      total++;
      if (err !== 1'b0 || res_data !== rv || vld_total != stl + 1 || unstable != 0) begin
        bad++;
        $display("FAIL %s result: err=%b res=%h valid_cycles=%0d unstable=%0d, want 0 %h %0d 0",
                 name, err, res_data, vld_total, unstable, rv, stl + 1);
      end
      last_res = rv;
    end
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || exec_start !== 1'b0 || ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after: busy=%b valid=%b start=%b ready=%b, want 0000",
               name, busy, res_valid, exec_start, ld_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({phase, busy, ld_ready, reg_wr_en, inst_wr_en, exec_start, res_valid, err, res_data}
        !== {2'b11, 7'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state: phase=%b busy=%b en=%b%b%b%b valid=%b err=%b res=%h",
               phase, busy, ld_ready, reg_wr_en, inst_wr_en, exec_start, res_valid, err, res_data);
    end
    rst = 1'b1;
    last_res = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (phase !== 2'b11 || busy !== 1'b0 || reg_wr_en !== 1'b0 || inst_wr_en !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold[%0d]: phase=%b busy=%b", i, phase, busy);
      end
    end
  endtask

  task automatic test_basic();
    do_run("basic", 8'h12, 8'h34, 8'h46, 5'd3, 0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_run("backpressure", DW'($urandom), DW'($urandom), DW'($urandom),
           5'($urandom_range(1, 16)), 1, $urandom_range(1, 3), 5, 1'b0, 1'b0);
  endtask

  task automatic test_lengths();
    do_run("len_zero", 8'hA1, 8'hB2, 8'hC3, 5'd0, 0, 2, 1, 1'b0, 1'b1);
    do_run("len_clamp", 8'h0F, 8'hF0, 8'h77, 5'd20, 2, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_run("timeout", 8'h11, 8'h22, 8'h99, 5'd3, 0, 1, 0, 1'b1, 1'b0);
    do_run("err_clear", 8'h33, 8'h44, 8'h55, 5'd2, 0, 1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    int cyc;
    ld_mode = 0; ex_lat = 1; hang = 1'b1; stall = 0;
    exwait_cycles = 0;
    @(posedge clk); #2;
    in_1 = 8'h01; in_2 = 8'h02; prog_len = 5'd4; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (exwait_cycles < 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({phase, busy, ld_ready, reg_wr_en, inst_wr_en, exec_start, res_valid, err, res_data, inst_addr}
        !== {2'b11, 7'b0, 8'h00, 4'h0} || cyc >= 500) begin
      bad++;
      $display("FAIL async_reset: phase=%b busy=%b start=%b err=%b res=%h addr=%h waited=%0d",
               phase, busy, exec_start, err, res_data, inst_addr, cyc);
    end
    last_res = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    do_run("after_reset", 8'h5C, 8'hC5, 8'h3E, 5'd5, 2, 2, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      do_run($sformatf("random%0d", r), DW'($urandom), DW'($urandom), DW'($urandom),
             5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(1, 4),
             $urandom_range(0, 4), 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_1 = '0; in_2 = '0; prog_len = '0;
    ld_valid = 1'b0; ld_data = '0; exec_done = 1'b0; res_ready = 1'b0;
    ld_mode = 0; ex_lat = 2; stall = 0; ld_idx = 0; ex_wait = 0;
    hang = 1'b0; start_noise = 1'b0; res_val = '0; last_res = '0;
    exec_seen = 0; exwait_cycles = 0; vld_total = 0; vld_seen = 0; unstable = 0;
    vld_first = '0;
    for (int i = 0; i < 16; i++) prog[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_lengths();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_phase_ctrl.md
Name: cpu_phase_ctrl

Overview:
- Sequencer for the 8-bit CPU datapath. It steps the register file and instruction memory through four phases: Load, Execute, Output, Idle.
- Load phase: writes the two input operands into the register file, then streams a program into instruction memory.
- Execute phase: issues each instruction to the execution unit with a start/done handshake.
- Output phase: reads the result register and presents it on a valid/ready port.

Parameters:
- DW, 8, operand/register data width
- IW, 8, instruction width
- RAW, 2, register file address width (4 registers)
- IAW, 4, instruction memory address width (16 entries)
- RES_REG, 2, register index read out in the Output phase
- EXEC_TO, 64, max cycles to wait for exec_done before error

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- in_1  in  DW  operand A, written to register 0
- in_2  in  DW  operand B, written to register 1
- prog_len  in  IAW+1  number of instructions to load and execute; sampled with start
- ld_valid  in  1  program word valid
- ld_data  in  IW  program word
- ld_ready  out  1  controller accepts program word
- reg_wr_en  out  1  register file write enable
- reg_addr  out  RAW  register file address
- reg_wr_data  out  DW  register file write data
- reg_rd_data  in  DW  register file read data, combinational from reg_addr
- inst_wr_en  out  1  instruction memory write enable
- inst_addr  out  IAW  instruction memory address (load pointer or PC)
- inst_wr_data  out  IW  instruction memory write data
- exec_start  out  1  one-cycle pulse: execute instruction at inst_addr
- exec_done  in  1  execution unit finished current instruction
- res_valid  out  1  result valid
- res_data  out  DW  result
- res_ready  in  1  consumer accepts result
- phase  out  2  00 Load, 01 Execute, 10 Output, 11 Idle
- busy  out  1  high in any state other than IDLE
- err  out  1  execution timeout occurred on the last run

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except phase=11; pc, load counter and watchdog cleared.
- States: IDLE, LD_R0, LD_R1, LD_INST, EX_ISSUE, EX_WAIT, OUT_RD, OUT_VLD.
- Phase mapping:
  - LD_* → 00
  - EX_* → 01
  - OUT_* → 10
  - IDLE → 11
- IDLE:
  - start=1: latch in_1, in_2 and len = min(prog_len, 2^IAW); clear err; go to LD_R0.
  - start is ignored in every other state.
- LD_R0: reg_wr_en=1, reg_addr=0, reg_wr_data=latched in_1 → LD_R1.
- LD_R1: same with address 1 and in_2. Next state is LD_INST if len>0, else OUT_RD (Execute skipped).
- LD_INST:
  - ld_ready=1.
  - On ld_valid&ld_ready: inst_wr_en=1, inst_addr=load count, inst_wr_data=ld_data; count increments.
  - After word len-1 → EX_ISSUE with pc=0.
  - ld_valid low: wait indefinitely, no write.
- EX_ISSUE: inst_addr=pc, exec_start=1 for exactly one cycle → EX_WAIT.
- EX_WAIT:
  - inst_addr held at pc. exec_done is sampled only here; exec_done during EX_ISSUE is ignored.
  - On exec_done: if pc==len-1 → OUT_RD, else pc+1 → EX_ISSUE. Throughput is 2 cycles per instruction minimum.
  - Watchdog counts EX_WAIT cycles. At EXEC_TO cycles without exec_done: err=1, go to IDLE. res_valid stays 0; res_data is not updated.
- OUT_RD: reg_addr=RES_REG; capture reg_rd_data into res_data → OUT_VLD.
- OUT_VLD:
  - res_valid=1, res_data stable.
  - res_ready=1 completes the transfer in that cycle → IDLE.
  - res_valid must not drop before acceptance.
- After a run:
  - res_data is held in IDLE until the next OUT_RD or reset; res_valid=0 in IDLE.
  - err holds until the next start.
- Outside their states: reg_wr_en, inst_wr_en, exec_start and ld_ready are 0; reg_addr and inst_addr are don't-care.
- Widths:
  - pc and load count are IAW+1 bits internally; inst_addr uses the low IAW bits.
  - prog_len values above 2^IAW are clamped to 2^IAW.
- Reset mid-run: returns to IDLE immediately; memory contents are not the controller's concern.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum
  - phase codes PH_LOAD=00, PH_EXEC=01, PH_OUT=10, PH_IDLE=11
  - register index constants OP_A_REG=0, OP_B_REG=1, RES_REG default 2
- One sub-module, cpu_exec_watchdog:
  - inputs: clear, enable
  - output: expired pulse after EXEC_TO enabled cycles

Test Plan:
- Reset then idle: rst low for 3 cycles → phase=11, busy=0, all enables 0; start held low for 20 cycles → no change.
- Basic run: in_1=0x12, in_2=0x34, prog_len=3, ld_valid always 1, exec_done 2 cycles after each exec_start.
  - Register writes: (0,0x12) then (1,0x34).
  - inst writes at addresses 0,1,2.
  - exec_start at pc 0,1,2.
  - reg_rd_data=0x46 at RES_REG → res_valid with res_data=0x46.
- Load backpressure and result stall: ld_valid toggles 1/0, res_ready low for 5 cycles.
  - Exactly prog_len writes, addresses contiguous.
  - res_valid and res_data stable until res_ready; then phase=11.
- prog_len=0: no inst_wr_en, no exec_start; Output follows LD_R1 directly. prog_len=20 → 16 writes and executions.
- Timeout: exec_done never asserted with EXEC_TO=64 → err=1 after 64 EX_WAIT cycles, phase=11, res_valid never 1. Next start clears err.
- Async reset mid-EX_WAIT: rst low between edges → outputs zero immediately, phase=11. A new start runs cleanly from pc=0.
